// File: rtl/voice_frame_window_pkg.sv
// Shared constants, FSM state type and Hamming coefficient generator for the
// voice framing windowing stage.
package voice_pkg;

  localparam int FRAME_LEN = 256;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int IDX_W     = 8;
  localparam int CNT_W     = 8;
  localparam int Q_SHIFT   = 15;
  localparam int PROD_W    = DATA_W + COEF_W + 1;

  localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1 << (Q_SHIFT - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX    = PROD_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN    = PROD_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_e;

  // Elaboration-time only: w(n) = round(32767 * (0.54 - 0.46*cos(2*pi*n/255))).
  function automatic logic [COEF_W-1:0] hamming_coef(input int n);
    real w;
    w = 32767.0 * (0.54 - 0.46 * $cos(2.0 * 3.14159265358979323846 * real'(n) / 255.0));
    return COEF_W'($rtoi(w + 0.5));
  endfunction

endpackage

// File: rtl/voice_frame_window_hamming_rom.sv
// 256-entry Hamming window ROM, Q1.15 unsigned, one synchronous read port.
module hamming_rom
  import voice_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  addr,
  output logic [COEF_W-1:0] data
);

  logic [COEF_W-1:0] table_s [FRAME_LEN];
  logic [COEF_W-1:0] data_q;

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_tab
    assign table_s[g] = hamming_coef(g);
  end

  // Registered read; the address is the index of the sample entering stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 16'd0;
    end else begin
      data_q <= table_s[addr];
    end
  end

  assign data = data_q;

endmodule

// File: rtl/voice_frame_window.sv
// Frame tracker plus 2-stage Hamming multiply / round-half-up / saturate pipeline
// sitting between the sliding-window collector and the FFT.
module voice_frame_window
  import voice_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_fft_busy,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_abort,
  output logic [IDX_W-1:0]  o_idx,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d, idx_inc_s;
  logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_sof_q, s1_sof_d;
  logic                       s1_eof_q, s1_eof_d;
  logic                       s1_abort_q, s1_abort_d;
  logic [IDX_W-1:0]           s1_idx_q;
  logic signed [DATA_W-1:0]   s1_data_q;
  logic [COEF_W-1:0]          coef_s;
  logic signed [PROD_W-1:0]   prod_s, rnd_s, shift_s;
  logic [DATA_W-1:0]          res_s;
  logic                       o_valid_q, o_sof_q, o_eof_q, o_abort_q;
  logic [IDX_W-1:0]           o_idx_q, o_idx_d;
  logic [DATA_W-1:0]          o_data_q, o_data_d;

  hamming_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (idx_d),
    .data (coef_s)
  );

  assign idx_inc_s = idx_q + 8'd1;

  // Frame tracking: an accepted sof always restarts at index 0 with a fresh busy decision.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drop_cnt_d = drop_cnt_q;
    s1_valid_d = 1'b0;
    s1_sof_d   = 1'b0;
    s1_eof_d   = 1'b0;
    s1_abort_d = 1'b0;
    if (i_valid && i_sof) begin
      idx_d      = 8'd0;
      s1_abort_d = (state_q == RUN);
      if (i_fft_busy) begin
        state_d = DROP;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end else begin
        state_d    = RUN;
        s1_valid_d = 1'b1;
        s1_sof_d   = 1'b1;
      end
    end else if (i_valid && (state_q != IDLE)) begin
      idx_d      = idx_inc_s;
      s1_valid_d = (state_q == RUN);
      s1_eof_d   = (state_q == RUN) && (idx_inc_s == 8'd255);
      if (idx_inc_s == 8'd255) begin
        state_d = IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control state and stage 1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      drop_cnt_q <= 8'd0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_abort_q <= 1'b0;
      s1_idx_q   <= 8'd0;
      s1_data_q  <= 16'sd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_sof_q   <= s1_sof_d;
      s1_eof_q   <= s1_eof_d;
      s1_abort_q <= s1_abort_d;
      s1_idx_q   <= idx_d;
      s1_data_q  <= i_data;
    end
  end

  // Coefficient is zero-extended so the product stays signed; shift is arithmetic (half-up).
  always_comb begin
    prod_s  = s1_data_q * $signed({1'b0, coef_s});
    rnd_s   = prod_s + ROUND_HALF;
    shift_s = rnd_s >>> Q_SHIFT;
    if (shift_s > SAT_MAX) begin
      res_s = 16'h7FFF;
    end else if (shift_s < SAT_MIN) begin
      res_s = 16'h8000;
    end else begin
      res_s = shift_s[DATA_W-1:0];
    end
    if (s1_valid_q) begin
      o_data_d = res_s;
      o_idx_d  = s1_idx_q;
    end else begin
      o_data_d = 16'd0;
      o_idx_d  = 8'd0;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_sof_q   <= 1'b0;
      o_eof_q   <= 1'b0;
      o_abort_q <= 1'b0;
      o_idx_q   <= 8'd0;
      o_data_q  <= 16'd0;
    end else begin
      o_valid_q <= s1_valid_q;
      o_sof_q   <= s1_sof_q;
      o_eof_q   <= s1_eof_q;
      o_abort_q <= s1_abort_q;
      o_idx_q   <= o_idx_d;
      o_data_q  <= o_data_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_sof      = o_sof_q;
  assign o_eof      = o_eof_q;
  assign o_abort    = o_abort_q;
  assign o_idx      = o_idx_q;
  assign o_data     = o_data_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_voice_frame_window.sv
// Self-checking bench for voice_frame_window: directed frames, a vector table
// and a randomized run scored against a frame-level reference model.
module tb_voice_frame_window;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_sof, i_fft_busy;
  logic [15:0] i_data;
  logic        o_valid, o_sof, o_eof, o_abort;
  logic [7:0]  o_idx, o_drop_cnt;
  logic [15:0] o_data;

  always #5 clk = ~clk;

  voice_frame_window dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .i_data     (i_data),
    .i_fft_busy (i_fft_busy),
    .o_valid    (o_valid),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_abort    (o_abort),
    .o_idx      (o_idx),
    .o_data     (o_data),
    .o_drop_cnt (o_drop_cnt)
  );

  typedef struct { bit v; bit sof; bit eof; bit abort; int idx; int data; } exp_t;
  typedef struct { int idx; int data; int expv; } vec_t;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference model: mode 0 = no frame, 1 = frame emitted, 2 = frame discarded.
  int   m_mode = 0;
  int   m_idx = 0;
  int   m_drops = 0;
  exp_t pend;

  // Observation of the output stream, cleared per directed sequence.
  int cap [256];
  int out_cnt, eof_cnt, eof_idx, sof_at0, abort_cnt, abort_aligned, mono_bad;
  int first_valid_step, last_valid_step, first_idx, next_idx, frame_start_step;
  int frame_data [256];

  function automatic exp_t zero_exp();
    exp_t z;
    z.v = 1'b0; z.sof = 1'b0; z.eof = 1'b0; z.abort = 1'b0; z.idx = 0; z.data = 0;
    return z;
  endfunction

  function automatic int coef(input int n);
    real w;
    w = 32767.0 * (0.54 - 0.46 * $cos(2.0 * 3.14159265358979323846 * real'(n) / 255.0));
    return $rtoi(w + 0.5);
  endfunction

  // floor((x*w + 2^14) / 2^15), clamped to the 16-bit signed range
  function automatic int win(input int x, input int n);
    longint t, q;
    t = longint'(x) * longint'(coef(n)) + 64'sd16384;
    q = t / 64'sd32768;
    if ((t < 0) && ((t % 64'sd32768) != 0)) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic clr_mon();
    out_cnt = 0; eof_cnt = 0; eof_idx = -1; sof_at0 = 0; abort_cnt = 0; abort_aligned = 0;
    mono_bad = 0; first_valid_step = -1; last_valid_step = -1; first_idx = -1; next_idx = 0;
    for (int i = 0; i < 256; i++) cap[i] = 99999;
  endtask

  task automatic drive(input bit r, input bit v, input bit s, input int d, input bit b);
    exp_t e, nv;
    rst = r; i_valid = v; i_sof = s; i_data = 16'(d); i_fft_busy = b;
    e  = r ? zero_exp() : pend;
    nv = zero_exp();
    if (r) begin
      m_mode = 0; m_idx = 0; m_drops = 0;
    end else if (v && s) begin
      nv.abort = (m_mode == 1);
      m_idx = 0;
      if (b) begin
        m_mode = 2;
        if (m_drops < 255) m_drops++;
      end else begin
        m_mode = 1;
        nv.v = 1'b1; nv.sof = 1'b1; nv.idx = 0; nv.data = win($signed(16'(d)), 0);
      end
    end else if (v && (m_mode != 0)) begin
      m_idx++;
      if (m_mode == 1) begin
        nv.v = 1'b1; nv.idx = m_idx; nv.data = win($signed(16'(d)), m_idx); nv.eof = (m_idx == 255);
      end
      if (m_idx == 255) m_mode = 0;
    end
    pend = nv;
    @(posedge clk);
    #1;
    step_no++;
    checks++;
    if (o_valid !== e.v || o_sof !== e.sof || o_eof !== e.eof || o_abort !== e.abort ||
        o_idx !== 8'(e.idx) || o_data !== 16'(e.data) || o_drop_cnt !== 8'(m_drops)) begin
      errors++;
      $display("FAIL model step %0d: got v=%0b sof=%0b eof=%0b abort=%0b idx=%0d data=%0d drops=%0d, expected v=%0b sof=%0b eof=%0b abort=%0b idx=%0d data=%0d drops=%0d",
               step_no, o_valid, o_sof, o_eof, o_abort, o_idx, $signed(o_data), o_drop_cnt,
               e.v, e.sof, e.eof, e.abort, e.idx, e.data, m_drops);
    end
    if (o_valid === 1'b1) begin
      out_cnt++;
      cap[o_idx] = int'($signed(o_data));
      if (first_valid_step < 0) begin
        first_valid_step = step_no;
        first_idx = int'(o_idx);
      end
      last_valid_step = step_no;
      if (o_sof === 1'b1) next_idx = 0;
      if (int'(o_idx) != next_idx) mono_bad++;
      next_idx = int'(o_idx) + 1;
      if (o_sof === 1'b1 && o_idx == 8'd0) sof_at0++;
    end
    if (o_eof === 1'b1) begin
      eof_cnt++;
      eof_idx = int'(o_idx);
    end
    if (o_abort === 1'b1) begin
      abort_cnt++;
      if (o_sof === 1'b1 && o_idx == 8'd0) abort_aligned++;
    end
  endtask

  task automatic send_frame(input bit busy, input bit gaps);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, i == 0, frame_data[i], busy);
      if (i == 0) frame_start_step = step_no;
      if (gaps) drive(1'b0, 1'b0, 1'b0, int'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{idx: 0,   data: 32767,  expv: 2621};
    vecs[1] = '{idx: 0,   data: -32768, expv: -2621};
    vecs[2] = '{idx: 0,   data: 1000,   expv: 80};
    vecs[3] = '{idx: 255, data: 1000,   expv: 80};
    vecs[4] = '{idx: 255, data: -32768, expv: -2621};
    vecs[5] = '{idx: 127, data: 1000,   expv: 1000};
    vecs[6] = '{idx: 128, data: 1000,   expv: 1000};
    pend = zero_exp();
    rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_data = 16'd0; i_fft_busy = 1'b0;

    // reset, including reset winning over a simultaneous sof
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1234, 1'b0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_data", int'(o_data), 0);
    check("reset_drop", int'(o_drop_cnt), 0);
    clr_mon();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("rst_prio_no_output", out_cnt, 0);

    // full frame of 1000
    for (int i = 0; i < 256; i++) frame_data[i] = 1000;
    clr_mon();
    send_frame(1'b0, 1'b0);
    check("full_count", out_cnt, 256);
    check("full_latency", first_valid_step - frame_start_step, 1);
    check("full_consecutive", last_valid_step - first_valid_step, 255);
    check("full_data0", cap[0], 80);
    check("full_data255", cap[255], 80);
    check("full_sof", sof_at0, 1);
    check("full_eof_cnt", eof_cnt, 1);
    check("full_eof_idx", eof_idx, 255);

    // vector table
    foreach (vecs[k]) begin
      for (int i = 0; i < 256; i++) frame_data[i] = 0;
      frame_data[vecs[k].idx] = vecs[k].data;
      clr_mon();
      send_frame(1'b0, 1'b0);
      check($sformatf("vec%0d_idx%0d", k, vecs[k].idx), cap[vecs[k].idx], vecs[k].expv);
    end

    // alternating full-scale sweep must never wrap sign
    for (int i = 0; i < 256; i++) frame_data[i] = (i % 2 == 1) ? -32768 : 32767;
    clr_mon();
    send_frame(1'b0, 1'b0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++)
        if ((frame_data[i] > 0 && cap[i] < 0) || (frame_data[i] < 0 && cap[i] > 0)) bad++;
      check("sweep_nowrap", bad, 0);
      check("sweep_count", out_cnt, 256);
    end

    // busy at sof drops the frame; the next one goes through
    for (int i = 0; i < 256; i++) frame_data[i] = 500 - i;
    clr_mon();
    send_frame(1'b1, 1'b0);
    check("drop_no_output", out_cnt, 0);
    check("drop_cnt_1", int'(o_drop_cnt), 1);
    clr_mon();
    send_frame(1'b0, 1'b0);
    check("after_drop_count", out_cnt, 256);
    check("after_drop_cnt_hold", int'(o_drop_cnt), 1);

    // gaps between samples
    clr_mon();
    send_frame(1'b0, 1'b1);
    check("gap_count", out_cnt, 256);
    check("gap_monotonic", mono_bad, 0);
    check("gap_eof_cnt", eof_cnt, 1);
    check("gap_eof_idx", eof_idx, 255);

    // truncation by a new sof at index 100
    clr_mon();
    for (int i = 0; i <= 100; i++) drive(1'b0, 1'b1, i == 0, frame_data[i], 1'b0);
    send_frame(1'b0, 1'b0);
    check("trunc_abort_cnt", abort_cnt, 1);
    check("trunc_abort_aligned", abort_aligned, 1);
    check("trunc_eof_cnt", eof_cnt, 1);
    check("trunc_out_cnt", out_cnt, 357);

    // reset in the middle of a frame
    for (int i = 0; i <= 50; i++) drive(1'b0, 1'b1, i == 0, frame_data[i], 1'b0);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_data", int'(o_data), 0);
    check("midrst_drop", int'(o_drop_cnt), 0);
    clr_mon();
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 777, 1'b0);
    check("midrst_no_output", out_cnt, 0);
    clr_mon();
    send_frame(1'b0, 1'b0);
    check("midrst_first_idx", first_idx, 0);
    check("midrst_count", out_cnt, 256);

    // drop counter saturation
    for (int k = 0; k < 260; k++) drive(1'b0, 1'b1, 1'b1, k, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("drop_sat", int'(o_drop_cnt), 255);

    // randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      drive($urandom_range(0, 1499) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 299) == 0, int'($urandom), $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_frame_window.md
# voice_frame_window

Windowing stage directly downstream of the 256-sample sliding-window collector and upstream of the FFT. Takes the collector's 16-bit sample stream, tracks frame position with its own counter aligned to a frame-start strobe, and multiplies each sample by a 256-point Hamming coefficient in Q1.15. Emits a windowed, rounded, saturated stream with index and start/end-of-frame markers. When the FFT reports busy at frame start, the whole frame is dropped.

## Interface
- FRAME_LEN, 256: samples per frame; fixed by the FFT size.
- DATA_W, 16: sample and output width, signed two's complement.
- COEF_W, 16: coefficient width, unsigned Q1.15, maximum value 32767.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- i_valid  in  1  i_data carries a sample this cycle.
- i_sof  in  1  this sample is index 0 of a frame; qualified by i_valid.
- i_data  in  16  signed sample from the collector.
- i_fft_busy  in  1  FFT cannot accept a frame; sampled only on an accepted sof.
- o_valid  out  1  o_data valid.
- o_sof  out  1  first windowed sample of an emitted frame.
- o_eof  out  1  sample index 255 of an emitted frame.
- o_abort  out  1  one-cycle pulse: an emitted frame was truncated by a new sof.
- o_idx  out  8  frame index of o_data.
- o_data  out  16  windowed sample.
- o_drop_cnt  out  8  count of dropped frames; saturates at 255.

## Operation
- FSM states:
  - IDLE: wait for i_valid && i_sof.
  - RUN: frame is being emitted.
  - DROP: frame is being discarded.
- Accepted sof goes to DROP if i_fft_busy=1, otherwise RUN. Index counter loads 0; the accepted sample is index 0.
- In RUN or DROP, each i_valid without sof increments the index. Gaps (i_valid=0) hold the index; no timeout.
- Index 255 accepted: return to IDLE. A sample with i_valid=1 and i_sof=0 in IDLE is ignored.
- sof in RUN or DROP before index 255 restarts the frame at index 0, with a fresh busy decision.
  - If the interrupted frame was RUN, o_abort pulses aligned with the new sample's output slot.
  - No o_eof is emitted for the truncated frame.
- DROP: no o_valid output. o_drop_cnt increments once per dropped frame, at the sof.
- Arithmetic:
  - prod = signed(i_data) * {0, coef}, 33-bit signed.
  - res = (prod + 2^14) >>> 15, arithmetic shift, so rounding is half-up.
  - Saturate res to [-32768, 32767].
- Coefficients: w(n) = round(32767 * (0.54 - 0.46*cos(2πn/255))), n = 0..255. Symmetric: w(n) = w(255-n). w(0) = 2621.

## Timing
- Latency is 2 cycles from the accepted input to o_valid.
  - Stage 1 registers the sample, the ROM coefficient (synchronous read addressed by the next index), the index and the flags.
  - Stage 2 registers the rounded, saturated result.
- Throughput is 1 sample per clock, with no backpressure toward the collector. o_valid follows i_valid, delayed 2 cycles, for RUN samples only.
- o_sof and o_eof are coincident with o_valid of index 0 and index 255.
- Reset:
  - FSM goes to IDLE and the index to 0.
  - Pipeline is flushed. All outputs are 0, including o_drop_cnt, from the cycle after rst is sampled high.
  - Reset mid-frame discards in-flight samples. No eof or abort is generated.
- rst has priority over simultaneous i_valid/i_sof.

## Structure
- Package voice_pkg holds FRAME_LEN, DATA_W, COEF_W, the FSM state enum (IDLE, RUN, DROP) and the Q-format shift constant (15).
- Sub-module hamming_rom: 256x16 synchronous-read ROM, generated constant table, one read port.
- FSM, counter and 2-stage multiply/round/saturate pipeline live in the top module.

## Test plan
- Full frame, busy=0: sof then 256 samples, all 1000 → o_valid for 256 consecutive cycles starting 2 cycles after sof.
  - o_data[0] = 80, o_sof at idx 0, o_eof at idx 255, o_data[255] = 80.
- Extremes at idx 0: 32767 → 2621; -32768 → -2621. Sweep the full frame with ±max and check no wrap.
- Busy drop: i_fft_busy=1 at sof → no o_valid for the frame, o_drop_cnt = 1. Next frame with busy=0 is emitted normally.
  - 260 dropped frames → o_drop_cnt holds 255.
- Gaps: i_valid toggling 1/0 across a frame → exactly 256 outputs, indices 0..255 monotonic, eof at 255.
- Truncation: new sof at idx 100 of a RUN frame → o_abort one pulse aligned with the new idx 0 output. No eof for the old frame; the new frame completes normally.
- Reset mid-frame at idx 50 → all outputs 0 next cycle. No output until the next sof; the following frame starts at idx 0.
